// File: rtl/float24_pkg.sv
// rtl/float24_pkg.sv - shared constants, FSM states and packing helper for the float24 front-end
package float24_pkg;

  localparam int EXP_BIAS = 63;
  localparam int EXP_W    = 7;
  localparam int MANT_W   = 16;
  localparam int FLOAT_W  = 24;
  localparam int SIGN_BIT = 23;
  localparam int EXP_MSB  = 22;
  localparam int EXP_LSB  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_DONE
  } state_e;

  // A zero magnitude always packs to all-zero so -0 cannot escape.
  function automatic logic [FLOAT_W-1:0] pack_float24(input logic sign,
                                                      input logic [EXP_W-1:0] exp,
                                                      input logic [MANT_W-1:0] mag);
    logic [FLOAT_W-1:0] f;
    f = '0;
    if (mag != '0) begin
      f[SIGN_BIT]        = sign;
      f[EXP_MSB:EXP_LSB] = exp;
      f[MANT_W-1:0]      = mag;
    end
    return f;
  endfunction

endpackage

// File: rtl/int_pair_to_float24_if.sv
// rtl/int_pair_to_float24_if.sv - operand-pair in / float-pair out handshake bundle
interface int_pair_to_float24_if;
  import float24_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [MANT_W-1:0]  int_a;
  logic [MANT_W-1:0]  int_b;
  logic               out_valid;
  logic               out_ready;
  logic [FLOAT_W-1:0] float_a;
  logic [FLOAT_W-1:0] float_b;

  modport master (
    output in_valid, int_a, int_b, out_ready,
    input  in_ready, out_valid, float_a, float_b
  );

  modport slave (
    input  in_valid, int_a, int_b, out_ready,
    output in_ready, out_valid, float_a, float_b
  );

endinterface

// File: rtl/int16_norm_lane.sv
// rtl/int16_norm_lane.sv - one lane: sign/magnitude capture then one left shift per step until normalised
module int16_norm_lane
  import float24_pkg::*;
#(
  parameter int BIAS = EXP_BIAS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [MANT_W-1:0] int_i,
  input  logic              step_i,
  output logic              done_o,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [MANT_W-1:0] mag_o
);

  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + MANT_W - 1);

  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0] mag_q, mag_d;

  assign done_o = mag_q[MANT_W-1] | (mag_q == '0);
  assign sign_o = sign_q;
  assign exp_o  = exp_q;
  assign mag_o  = mag_q;

  // Negating -32768 wraps to 0x8000, which is exactly the wanted magnitude.
  always_comb begin
    sign_d = sign_q;
    exp_d  = exp_q;
    mag_d  = mag_q;
    if (load_i) begin
      sign_d = int_i[MANT_W-1];
      mag_d  = int_i[MANT_W-1] ? (~int_i + MANT_W'(1)) : int_i;
      exp_d  = EXP_INIT;
    end else if (step_i && !done_o) begin
      mag_d = {mag_q[MANT_W-2:0], 1'b0};
      exp_d = exp_q - EXP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      mag_q  <= '0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      mag_q  <= mag_d;
    end
  end

endmodule

// File: rtl/int_pair_to_float24.sv
// rtl/int_pair_to_float24.sv - converts a signed 16-bit operand pair into two float24 values
module int_pair_to_float24
  import float24_pkg::*;
#(
  parameter int BIAS = EXP_BIAS
) (
  input logic                  clk,
  input logic                  rst,
  int_pair_to_float24_if.slave bus
);

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [FLOAT_W-1:0] float_a_q;
  logic [FLOAT_W-1:0] float_b_q;

  logic              accept;
  logic              step;
  logic              done_a, done_b;
  logic              sign_a, sign_b;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [MANT_W-1:0] mag_a, mag_b;

  assign accept = (state_q == ST_IDLE) && bus.in_valid;
  assign step   = (state_q == ST_NORM);

  int16_norm_lane #(.BIAS(BIAS)) u_lane_a (
    .clk(clk), .rst(rst), .load_i(accept), .int_i(bus.int_a), .step_i(step),
    .done_o(done_a), .sign_o(sign_a), .exp_o(exp_a), .mag_o(mag_a)
  );

  int16_norm_lane #(.BIAS(BIAS)) u_lane_b (
    .clk(clk), .rst(rst), .load_i(accept), .int_i(bus.int_b), .step_i(step),
    .done_o(done_b), .sign_o(sign_b), .exp_o(exp_b), .mag_o(mag_b)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.float_a   = float_a_q;
  assign bus.float_b   = float_b_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      float_a_q   <= '0;
      float_b_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_q    <= ST_NORM;
            in_ready_q <= 1'b0;
          end
        end
        ST_NORM: begin
          // The lane that finishes first simply idles until the slower one catches up.
          if (done_a && done_b) begin
            float_a_q   <= pack_float24(sign_a, exp_a, mag_a);
            float_b_q   <= pack_float24(sign_b, exp_b, mag_b);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_pair_to_float24.sv
// tb/tb_int_pair_to_float24.sv - self-checking bench for int_pair_to_float24
module tb_int_pair_to_float24;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int_pair_to_float24_if bus();

  int_pair_to_float24 dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic int msb_of(input int a);
    return $clog2(a + 1) - 1;
  endfunction

  // Value = m/2^15 * 2^(e-63), m in [0x8000, 0xFFFF], so e-63 is floor(log2|v|).
  function automatic logic [23:0] ref_float(input logic [15:0] raw);
    int         iv;
    int         a;
    int         msb;
    logic [6:0] e7;
    logic [15:0] m16;
    iv = int'($signed(raw));
    if (iv == 0) return 24'h0;
    a   = (iv < 0) ? -iv : iv;
    msb = msb_of(a);
    e7  = 7'(63 + msb);
    m16 = 16'(a * (1 << (15 - msb)));
    return {(iv < 0), e7, m16};
  endfunction

  function automatic int ref_k(input logic [15:0] raw);
    int iv;
    iv = int'($signed(raw));
    if (iv == 0) return 0;
    return 15 - msb_of((iv < 0) ? -iv : iv);
  endfunction

  function automatic logic [15:0] rand_operand();
    logic [15:0] r;
    int          sh;
    r  = 16'($urandom);
    sh = int'($urandom_range(0, 16));
    if (sh == 16) return 16'h0;
    return 16'($signed(r) >>> sh);
  endfunction

  // Stimulus only: offers a pair, reports latency and outputs; callers compare.
  task automatic do_pair(input logic [15:0] a, input logic [15:0] b, output int lat,
                         output logic [23:0] fa, output logic [23:0] fb, output logic rdy);
    rdy = bus.in_ready;
    bus.in_valid = 1'b1;
    bus.int_a    = a;
    bus.int_b    = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    fa = bus.float_a;
    fb = bus.float_b;
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.float_a !== 24'h0 || bus.float_b !== 24'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b fa=%h fb=%h exp rdy=1 vld=0 fa=0 fb=0",
               bus.in_ready, bus.out_valid, bus.float_a, bus.float_b);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_plan_vectors();
    logic [15:0] va [4] = '{16'h0001, 16'h4000, 16'h8000, 16'h0000};
    logic [15:0] vb [4] = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h0000};
    logic [23:0] ea [4] = '{24'h3F8000, 24'h4D8000, 24'hCE8000, 24'h000000};
    logic [23:0] eb [4] = '{24'hBF8000, 24'h000000, 24'h4DFFFE, 24'h000000};
    int          el [4] = '{16, 2, 2, 1};
    int          lat;
    logic [23:0] fa, fb;
    logic        rdy;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_pair(va[i], vb[i], lat, fa, fb, rdy);
      checks++;
      if (fa !== ea[i] || fb !== eb[i] || lat !== el[i] || rdy !== 1'b1) begin
        errors++;
        $display("FAIL plan_vec%0d got fa=%h fb=%h lat=%0d rdy=%b exp fa=%h fb=%h lat=%0d rdy=1",
                 i, fa, fb, lat, rdy, ea[i], eb[i], el[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    int          lat, k;
    logic [23:0] fa, fb;
    logic        rdy;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = rand_operand();
      b = rand_operand();
      k = (ref_k(a) > ref_k(b)) ? ref_k(a) : ref_k(b);
      do_pair(a, b, lat, fa, fb, rdy);
      checks++;
      if (fa !== ref_float(a) || fb !== ref_float(b) || lat !== k + 1) begin
        errors++;
        $display("FAIL random a=%h b=%h got fa=%h fb=%h lat=%0d exp fa=%h fb=%h lat=%0d",
                 a, b, fa, fb, lat, ref_float(a), ref_float(b), k + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.int_a     = 16'd3;
    bus.int_b     = 16'd5;
    @(posedge clk); #1;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      bus.int_a = 16'($urandom);
      bus.int_b = 16'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL bp_latency got %0d exp 15", lat);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.float_a !== 24'h40C000 || bus.float_b !== 24'h41A000 ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got fa=%h fb=%h vld=%b rdy=%b exp fa=40c000 fb=41a000 vld=1 rdy=0",
                 i, bus.float_a, bus.float_b, bus.out_valid, bus.in_ready);
      end
      bus.int_a = 16'($urandom);
      bus.int_b = 16'($urandom);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_in_flight();
    int          lat;
    logic [23:0] fa, fb;
    logic        rdy;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.int_a     = 16'd1;
    bus.int_b     = 16'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.float_a !== 24'h0 || bus.float_b !== 24'h0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_norm got vld=%b fa=%h fb=%h rdy=%b exp vld=0 fa=0 fb=0 rdy=1",
               bus.out_valid, bus.float_a, bus.float_b, bus.in_ready);
    end
    do_pair(16'd2, 16'd2, lat, fa, fb, rdy);
    checks++;
    if (fa !== 24'h408000 || fb !== 24'h408000 || lat !== 15 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_norm_next got fa=%h fb=%h lat=%0d rdy=%b exp fa=408000 fb=408000 lat=15 rdy=1",
               fa, fb, lat, rdy);
    end
    bus.out_ready = 1'b0;
    do_pair(16'h8000, 16'h0000, lat, fa, fb, rdy);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.float_a !== 24'h0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_done got vld=%b fa=%h rdy=%b exp vld=0 fa=0 rdy=1",
               bus.out_valid, bus.float_a, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    int          lat, k;
    int unsigned start, expect_cycles;
    logic [23:0] fa, fb;
    logic        rdy;
    bit          ok;
    bus.out_ready = 1'b1;
    start = cyc;
    expect_cycles = 0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = rand_operand();
      b = rand_operand();
      k = (ref_k(a) > ref_k(b)) ? ref_k(a) : ref_k(b);
      expect_cycles += k + 3;
      do_pair(a, b, lat, fa, fb, rdy);
      if (rdy !== 1'b1 || fa !== ref_float(a) || fb !== ref_float(b)) ok = 1'b0;
    end
    checks++;
    if (!ok || (cyc - start) !== expect_cycles) begin
      errors++;
      $display("FAIL back_to_back got cycles=%0d ok=%b exp cycles=%0d ok=1",
               cyc - start, ok, expect_cycles);
    end
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.int_a     = 16'h0;
    bus.int_b     = 16'h0;
    bus.out_ready = 1'b1;
    test_reset();
    test_plan_vectors();
    test_random();
    test_backpressure();
    test_reset_in_flight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
